// File: rtl/zad_5_2_divider_if.sv
// Start/ready handshake and data bus of the 48/24 restoring divider.
// The master side drives the request and operands; the slave side is the divider.
interface zad_5_2_divider_if;
    logic        start;
    logic        ready;
    logic [47:0] input0;
    logic [23:0] input1;
    logic [23:0] output0;
    logic [23:0] output1;
    logic        div_zero;
    logic        overflow;

    modport master (
        output start, input0, input1,
        input  ready, output0, output1, div_zero, overflow
    );

    modport slave (
        input  start, input0, input1,
        output ready, output0, output1, div_zero, overflow
    );
endinterface

// File: rtl/zad_5_2_divider.sv
// zad_5_2_divider: multi-cycle unsigned restoring divider, 48-bit dividend by
// 24-bit divisor, one quotient bit per cycle, start/ready handshake.
// Optional feature macro: OVF_CHECK_EN
//   defined   - dividend[47:24] >= divisor is flagged as overflow up front and
//               a normal division runs 24 iterations over dividend[23:0].
//   undefined - no pre-check, 48 iterations, quotient truncated to 24 bits,
//               overflow output tied low.
module zad_5_2_divider (
    input  logic               clk,
    input  logic               rst_n,
    zad_5_2_divider_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

`ifdef OVF_CHECK_EN
    localparam logic [5:0] LAST_CNT = 6'd23;
`else
    localparam logic [5:0] LAST_CNT = 6'd47;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [47:0] r_dividend;
    logic [23:0] r_divisor;
    logic [23:0] r_rem;
    logic [23:0] r_quo;
    logic [5:0]  r_cnt;
    logic [23:0] r_out0;
    logic [23:0] r_out1;
    logic        r_dz;

    logic [24:0] w_t;
    logic        w_ge;
    logic [23:0] w_rem_next;
    logic [23:0] w_quo_next;

`ifdef OVF_CHECK_EN
    logic        r_ovf;
    logic        w_ovf;
    assign w_ovf = (r_dividend[47:24] >= r_divisor);
    assign bus.overflow = r_ovf;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.ready    = (r_state == DONE);
    assign bus.output0  = r_out0;
    assign bus.output1  = r_out1;
    assign bus.div_zero = r_dz;

    // One restoring step: shift in the next dividend MSB, subtract if it fits.
    // The remainder stays below the divisor, so 24 stored bits suffice; only t needs 25.
    always_comb begin
        w_t        = {r_rem, r_dividend[47]};
        w_ge       = (w_t >= {1'b0, r_divisor});
        w_rem_next = w_ge ? 24'(w_t - {1'b0, r_divisor}) : w_t[23:0];
        w_quo_next = {r_quo[22:0], w_ge};
    end

    // Next-state logic of the control FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (bus.start) w_state_next = CHECK;
            CHECK: begin
                if (r_divisor == '0) begin
                    w_state_next = DONE;
                end
`ifdef OVF_CHECK_EN
                else if (w_ovf) begin
                    w_state_next = DONE;
                end
`endif
                else begin
                    w_state_next = DIV;
                end
            end
            DIV:   if (r_cnt == '0) w_state_next = DONE;
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_out0     <= '0;
            r_out1     <= '0;
            r_dz       <= 1'b0;
`ifdef OVF_CHECK_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dividend <= bus.input0;
                        r_divisor  <= bus.input1;
                    end
                end
                CHECK: begin
                    if (r_divisor == '0) begin
                        r_out0 <= '1;
                        r_out1 <= r_dividend[23:0];
                        r_dz   <= 1'b1;
`ifdef OVF_CHECK_EN
                        r_ovf  <= 1'b0;
                    end else if (w_ovf) begin
                        r_out0 <= '1;
                        r_out1 <= '0;
                        r_dz   <= 1'b0;
                        r_ovf  <= 1'b1;
                    end else begin
                        // High half seeds the remainder; only the low half is iterated.
                        r_rem      <= r_dividend[47:24];
                        r_dividend <= {r_dividend[23:0], 24'd0};
                        r_quo      <= '0;
                        r_cnt      <= LAST_CNT;
                    end
`else
                    end else begin
                        r_rem <= '0;
                        r_quo <= '0;
                        r_cnt <= LAST_CNT;
                    end
`endif
                end
                DIV: begin
                    r_rem      <= w_rem_next;
                    r_quo      <= w_quo_next;
                    r_dividend <= {r_dividend[46:0], 1'b0};
                    r_cnt      <= r_cnt - 6'd1;
                    if (r_cnt == '0) begin
                        r_out0 <= w_quo_next;
                        r_out1 <= w_rem_next;
                        r_dz   <= 1'b0;
`ifdef OVF_CHECK_EN
                        r_ovf  <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zad_5_2_divider.sv
// Self-checking bench for zad_5_2_divider: an arithmetic reference model
// (/ and %) predicts results and ready timing; outputs are compared every cycle,
// and directed cases carry hand-computed literal expectations.
module tb_zad_5_2_divider;

`ifdef OVF_CHECK_EN
    localparam int LAT_N = 25;
`else
    localparam int LAT_N = 49;
`endif

    logic clk;
    logic rst_n;
    zad_5_2_divider_if bus();

    zad_5_2_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit scramble = 1'b0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic plus the documented latency in edges from E to DONE.
    function automatic void model_div(input logic [47:0] a, input logic [23:0] b,
                                      output logic [23:0] q, output logic [23:0] r,
                                      output logic dz, output logic ovf, output int lat);
        logic [47:0] fq;
        dz  = 1'b0;
        ovf = 1'b0;
        fq  = '0;
        if (b == 24'd0) begin
            dz  = 1'b1;
            q   = 24'hFFFFFF;
            r   = a[23:0];
            lat = 1;
        end else begin
            fq  = a / {24'd0, b};
            q   = fq[23:0];
            r   = 24'(a % {24'd0, b});
            lat = LAT_N;
`ifdef OVF_CHECK_EN
            if (fq > 48'h0000_00FF_FFFF) begin
                ovf = 1'b1;
                q   = 24'hFFFFFF;
                r   = 24'd0;
                lat = 1;
            end
`endif
        end
    endfunction

    int          edge_n = 0;
    int          m_due  = 0;
    bit          m_busy = 1'b0;
    bit          m_cool = 1'b0;
    logic        m_ready = 1'b0;
    logic [23:0] m_q = '0, m_r = '0, p_q, p_r;
    logic        m_dz = 1'b0, m_ovf = 1'b0, p_dz, p_ovf;
    int          p_lat;

    // Transaction-level model: accept in idle, publish results after the latency,
    // spend one further edge leaving the done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_cool = 1'b0; m_ready = 1'b0;
            m_q = '0; m_r = '0; m_dz = 1'b0; m_ovf = 1'b0;
        end else begin
            edge_n++;
            m_ready = 1'b0;
            if (m_busy) begin
                if (edge_n == m_due) begin
                    m_busy = 1'b0; m_cool = 1'b1; m_ready = 1'b1;
                    m_q = p_q; m_r = p_r; m_dz = p_dz; m_ovf = p_ovf;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (bus.start) begin
                model_div(bus.input0, bus.input1, p_q, p_r, p_dz, p_ovf, p_lat);
                m_due  = edge_n + p_lat;
                m_busy = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ready",    {47'd0, bus.ready},    {47'd0, m_ready});
        chk("output0",  {24'd0, bus.output0},  {24'd0, m_q});
        chk("output1",  {24'd0, bus.output1},  {24'd0, m_r});
        chk("div_zero", {47'd0, bus.div_zero}, {47'd0, m_dz});
        chk("overflow", {47'd0, bus.overflow}, {47'd0, m_ovf});
    end

    // Waits for ready, counting negedges from cyc0; randomises operands if scramble is set.
    task automatic wait_ready(input int cyc0, output int cyc);
        cyc = cyc0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.ready) break;
            if (scramble) begin
                bus.input0 = {$urandom, $urandom};
                bus.input1 = 24'($urandom);
            end
            if (cyc > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL ready_timeout: no ready after %0d cycles", cyc);
                break;
            end
        end
    endtask

    // One operation with start pulsed for a single edge; checks literal results and latency.
    task automatic run_op(input string name, input logic [47:0] a, input logic [23:0] b,
                          input logic [23:0] eq, input logic [23:0] er,
                          input logic edz, input logic eovf, input int elat);
        int cyc;
        @(negedge clk);
        bus.input0 = a;
        bus.input1 = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_ready(1, cyc);
        chk({name, "_q"},   {24'd0, bus.output0}, {24'd0, eq});
        chk({name, "_r"},   {24'd0, bus.output1}, {24'd0, er});
        chk({name, "_dz"},  {47'd0, bus.div_zero}, {47'd0, edz});
        chk({name, "_ovf"}, {47'd0, bus.overflow}, {47'd0, eovf});
        chk({name, "_lat"}, 48'(cyc), 48'(elat + 1));
        scramble = 1'b0;
    endtask

    int c1, c2, c3;

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.input0 = '0;
        bus.input1 = '0;
        #1;
        chk("rst_ready", {47'd0, bus.ready}, 48'd0);
        chk("rst_q",     {24'd0, bus.output0}, 48'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1000_7", 48'd1000, 24'd7, 24'd142, 24'd6, 1'b0, 1'b0, LAT_N);
        run_op("dz", 48'h000000_ABCDEF, 24'd0, 24'hFFFFFF, 24'hABCDEF, 1'b1, 1'b0, 1);
`ifdef OVF_CHECK_EN
        run_op("ovf", 48'h000001_000000, 24'd1, 24'hFFFFFF, 24'd0, 1'b0, 1'b1, 1);
`else
        run_op("ovf", 48'h000001_000000, 24'd1, 24'h000000, 24'd0, 1'b0, 1'b0, LAT_N);
`endif
        scramble = 1'b1;
        run_op("maxq", 48'hFFFFFE_000001, 24'hFFFFFF, 24'hFFFFFF, 24'd0, 1'b0, 1'b0, LAT_N);
        run_op("t5_7", 48'd5, 24'd7, 24'd0, 24'd5, 1'b0, 1'b0, LAT_N);

        // Abort mid-division: reset in the 10th DIV iteration.
        @(negedge clk);
        bus.input0 = 48'd1000;
        bus.input1 = 24'd7;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", {47'd0, bus.ready}, 48'd0);
        chk("abort_q",     {24'd0, bus.output0}, 48'd0);
        chk("abort_r",     {24'd0, bus.output1}, 48'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT_N + 4) @(negedge clk);
        chk("abort_no_ready_q", {24'd0, bus.output0}, 48'd0);
        run_op("t100_9", 48'd100, 24'd9, 24'd11, 24'd1, 1'b0, 1'b0, LAT_N);

        // start held high across three back-to-back operations.
        @(negedge clk);
        bus.input0 = 48'd1000;
        bus.input1 = 24'd7;
        bus.start  = 1'b1;
        wait_ready(0, c1);
        chk("held1_q", {24'd0, bus.output0}, 48'd142);
        chk("held1_r", {24'd0, bus.output1}, 48'd6);
        chk("held1_lat", 48'(c1), 48'(LAT_N + 1));
        bus.input0 = 48'd100;
        bus.input1 = 24'd9;
        @(negedge clk);
        chk("held1_single_pulse", {47'd0, bus.ready}, 48'd0);
        wait_ready(1, c2);
        chk("held2_q", {24'd0, bus.output0}, 48'd11);
        chk("held2_r", {24'd0, bus.output1}, 48'd1);
        chk("held2_spacing", 48'(c2), 48'(LAT_N + 2));
        bus.input0 = 48'd5;
        bus.input1 = 24'd5;
        wait_ready(0, c3);
        bus.start = 1'b0;
        chk("held3_q", {24'd0, bus.output0}, 48'd1);
        chk("held3_r", {24'd0, bus.output1}, 48'd0);
        chk("held3_spacing", 48'(c3), 48'(LAT_N + 2));
        @(negedge clk);
        chk("held3_single_pulse", {47'd0, bus.ready}, 48'd0);
        repeat (LAT_N + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
